// File: rtl/sklansky_sub_pipe_if.sv
// Valid/ready operand and result bus for the pipelined Sklansky subtractor.
// The slave side is the subtractor; the master side is its producer/consumer.
interface sklansky_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/sklansky_sub_pipe.sv
// Three-stage valid/ready subtractor diff = a - b - bin, computed as a + ~b + ~bin
// with a Sklansky prefix tree split between stage 1 and stage 2.
module sklansky_sub_pipe #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 2
) (
  input logic               clk,
  input logic               rst,
  sklansky_sub_pipe_if.slave bus
);
  localparam int LOG = $clog2(WIDTH);
  localparam int IW  = LOG;

  logic             v0_r, v1_r, v2_r;
  logic             adv0_s, adv1_s, adv2_s;
  logic [WIDTH-1:0] p0_r, g0_r;
  logic             glsb0_r, amsb0_r, bmsb0_r;
  logic [WIDTH-1:0] gg1_r, pp1_r, p1_r;
  logic             glsb1_r, amsb1_r, bmsb1_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r, ovf_r;
  logic [2*WIDTH-1:0] gp1_s, gp2_s;
  logic [WIDTH:0]     carry_s;
  logic [WIDTH-1:0]   sum_s;
  logic               ovf_s;

  // One Sklansky level: upper half of each 2^(lvl+1) block merges with the top of the lower half.
  function automatic logic [2*WIDTH-1:0] sk_level(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int lvl);
    logic [WIDTH-1:0] go, po;
    int j;
    go = g;
    po = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> lvl) & 32'sd1) == 32'sd1) begin
        j     = ((i >> lvl) << lvl) - 32'sd1;
        go[i] = g[i] | (p[i] & g[IW'(j)]);
        po[i] = p[i] & p[IW'(j)];
      end else begin
        go[i] = g[i];
        po[i] = p[i];
      end
    end
    return {go, po};
  endfunction

  // Bubble-collapsing advance chain; in_ready never looks at in_valid.
  always_comb begin
    adv2_s = ~v2_r | bus.out_ready;
    adv1_s = ~v1_r | adv2_s;
    adv0_s = ~v0_r | adv1_s;
  end

  assign bus.in_ready  = adv0_s & ~rst;
  assign bus.out_valid = v2_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;

  // Prefix levels 0..SPLIT-1 evaluated between S0 and S1.
  always_comb begin
    gp1_s = {g0_r, p0_r};
    for (int l = 0; l < LOG; l++) begin
      gp1_s = (l < SPLIT) ? sk_level(gp1_s[2*WIDTH-1:WIDTH], gp1_s[WIDTH-1:0], l) : gp1_s;
    end
  end

  // Remaining levels, then the grey cell folding in the carry-in, sum bits and flags.
  always_comb begin
    gp2_s = {gg1_r, pp1_r};
    for (int l = 0; l < LOG; l++) begin
      gp2_s = (l >= SPLIT) ? sk_level(gp2_s[2*WIDTH-1:WIDTH], gp2_s[WIDTH-1:0], l) : gp2_s;
    end
    carry_s = {gp2_s[2*WIDTH-1:WIDTH] | (gp2_s[WIDTH-1:0] & {WIDTH{glsb1_r}}), glsb1_r};
    sum_s   = p1_r ^ carry_s[WIDTH-1:0];
    ovf_s   = (amsb1_r ^ bmsb1_r) & (sum_s[WIDTH-1] ^ amsb1_r);
  end

  // Pipeline state: valids follow the advance chain, data loads only behind a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_r    <= 1'b0;
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      p0_r    <= {WIDTH{1'b0}};
      g0_r    <= {WIDTH{1'b0}};
      glsb0_r <= 1'b0;
      amsb0_r <= 1'b0;
      bmsb0_r <= 1'b0;
      gg1_r   <= {WIDTH{1'b0}};
      pp1_r   <= {WIDTH{1'b0}};
      p1_r    <= {WIDTH{1'b0}};
      glsb1_r <= 1'b0;
      amsb1_r <= 1'b0;
      bmsb1_r <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (adv0_s) begin
        v0_r <= bus.in_valid;
        if (bus.in_valid) begin
          p0_r    <= bus.a ^ ~bus.b;
          g0_r    <= bus.a & ~bus.b;
          glsb0_r <= ~bus.bin;
          amsb0_r <= bus.a[WIDTH-1];
          bmsb0_r <= bus.b[WIDTH-1];
        end
      end
      if (adv1_s) begin
        v1_r <= v0_r;
        if (v0_r) begin
          gg1_r   <= gp1_s[2*WIDTH-1:WIDTH];
          pp1_r   <= gp1_s[WIDTH-1:0];
          p1_r    <= p0_r;
          glsb1_r <= glsb0_r;
          amsb1_r <= amsb0_r;
          bmsb1_r <= bmsb0_r;
        end
      end
      if (adv2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          diff_r <= sum_s;
          bout_r <= ~carry_s[WIDTH];
          ovf_r  <= ovf_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Scoreboard bench for sklansky_sub_pipe: WIDTH=8 directed/random/backpressure checks
// plus a WIDTH 4/16/32 sweep, all against an arithmetic reference model.
module tb_sklansky_sub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sklansky_sub_pipe_if #(.WIDTH(8))  bus();
  sklansky_sub_pipe_if #(.WIDTH(4))  bus4();
  sklansky_sub_pipe_if #(.WIDTH(16)) bus16();
  sklansky_sub_pipe_if #(.WIDTH(32)) bus32();

  sklansky_sub_pipe #(.WIDTH(8),  .SPLIT(2)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  sklansky_sub_pipe #(.WIDTH(4),  .SPLIT(0)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  sklansky_sub_pipe #(.WIDTH(16), .SPLIT(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  sklansky_sub_pipe #(.WIDTH(32), .SPLIT(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  logic        sw_valid = 1'b0;
  logic [31:0] sw_a = 32'd0;
  logic [31:0] sw_b = 32'd0;
  logic        sw_bin = 1'b0;

  assign bus4.in_valid   = sw_valid;
  assign bus4.a          = sw_a[3:0];
  assign bus4.b          = sw_b[3:0];
  assign bus4.bin        = sw_bin;
  assign bus4.out_ready  = 1'b1;
  assign bus16.in_valid  = sw_valid;
  assign bus16.a         = sw_a[15:0];
  assign bus16.b         = sw_b[15:0];
  assign bus16.bin       = sw_bin;
  assign bus16.out_ready = 1'b1;
  assign bus32.in_valid  = sw_valid;
  assign bus32.a         = sw_a;
  assign bus32.b         = sw_b;
  assign bus32.bin       = sw_bin;
  assign bus32.out_ready = 1'b1;

  // Reference: {ovf, bout, diff[31:0]} from plain integer arithmetic at width w.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    longint m, half, aa, bb, bi, d, sa, sb, sd;
    logic [63:0] dbits;
    logic bo, ov;
    m    = (64'sd1 <<< w) - 64'sd1;
    half = 64'sd1 <<< (w - 1);
    aa   = longint'(a) & m;
    bb   = longint'(b) & m;
    bi   = bin ? 64'sd1 : 64'sd0;
    d    = (aa - bb - bi) & m;
    dbits = d;
    bo   = (aa < bb + bi);
    sa   = (aa >= half) ? aa - (m + 64'sd1) : aa;
    sb   = (bb >= half) ? bb - (m + 64'sd1) : bb;
    sd   = sa - sb - bi;
    ov   = (sd < -half) || (sd > half - 64'sd1);
    return {ov, bo, dbits[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         acc;
    bit         chk_lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    int          acc;
  } sw_t;
  sw_t sq[$];

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit chk);
    exp_t e;
    logic [33:0] r;
    r = model(8, {24'd0, a}, {24'd0, b}, bin);
    e.diff = r[7:0];
    e.bout = r[32];
    e.ovf = r[33];
    e.acc = cyc + 1;
    e.chk_lat = chk;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input bit chk, input bit need_ready);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (need_ready) check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      if (bus.in_ready) begin
        push(a, b, bin, chk);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: actual in_ready stuck 0 required accept within 20 cycles");
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Main monitor: pops on every handshake, checks data, order, latency and stall hold.
  initial begin
    exp_t e;
    bit stall_prev;
    logic [9:0] held;
    stall_prev = 1'b0;
    held = 10'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        q.delete();
      end else begin
        if (stall_prev)
          check("hold", {53'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf}, {53'd0, 1'b1, held});
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: actual beat diff=%0h required none", bus.diff);
          end else begin
            e = q.pop_front();
            check("result", {54'd0, bus.diff, bus.bout, bus.ovf}, {54'd0, e.diff, e.bout, e.ovf});
            // The handshake edge is the one after this sample, i.e. cyc+1.
            if (e.chk_lat) check("latency", 64'(cyc + 1 - e.acc), 64'd3);
          end
        end
        stall_prev = bus.out_valid & ~bus.out_ready;
        held = {bus.diff, bus.bout, bus.ovf};
      end
    end
  end

  // Sweep monitor: the three widths must present each result exactly two samples after acceptance.
  initial begin
    sw_t s;
    logic [33:0] r;
    bit ev;
    forever begin
      @(negedge clk);
      if (rst) begin
        sq.delete();
      end else begin
        ev = (sq.size() > 0) && (sq[0].acc + 2 == cyc);
        if (ev || bus4.out_valid || bus16.out_valid || bus32.out_valid) begin
          check("sw4_valid",  {63'd0, bus4.out_valid},  {63'd0, ev});
          check("sw16_valid", {63'd0, bus16.out_valid}, {63'd0, ev});
          check("sw32_valid", {63'd0, bus32.out_valid}, {63'd0, ev});
          if (ev) begin
            s = sq.pop_front();
            r = model(4, s.a, s.b, s.bin);
            check("sw4",  {58'd0, bus4.bout, bus4.ovf, bus4.diff},   {58'd0, r[32], r[33], r[3:0]});
            r = model(16, s.a, s.b, s.bin);
            check("sw16", {46'd0, bus16.bout, bus16.ovf, bus16.diff}, {46'd0, r[32], r[33], r[15:0]});
            r = model(32, s.a, s.b, s.bin);
            check("sw32", {30'd0, bus32.bout, bus32.ovf, bus32.diff}, {30'd0, r[32], r[33], r[31:0]});
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] bp_exp [3];
    sw_t s;
    int t;
    bp_exp[0] = 8'h0F;
    bp_exp[1] = 8'h1E;
    bp_exp[2] = 8'h2D;
    bus.in_valid = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {52'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    @(posedge clk);
    #1;

    // Directed basic, wrap, borrow-in and overflow cases
    send(8'h05, 8'h03, 1'b0, 1'b1, 1'b1);
    send(8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
    send(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1);
    send(8'h7F, 8'hFF, 1'b0, 1'b1, 1'b1);
    idle(6);

    // Reset with two beats in flight; a beat offered during reset must be ignored
    send(8'h55, 8'h11, 1'b0, 1'b1, 1'b1);
    send(8'h66, 8'h22, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    bus.a = 8'h99;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("in_reset", {52'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("after_reset", {53'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf}, 64'd0);
    @(posedge clk);
    #1;
    idle(4);
    send(8'h42, 8'h21, 1'b0, 1'b1, 1'b1);
    idle(6);

    // Full-rate streaming
    for (int i = 0; i < 256; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1);
    idle(6);

    // Random valid and random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.bin = 1'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) push(bus.a, bus.b, bus.bin, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    idle(8);

    // Fill the pipe under a stall, hold, then drain on consecutive cycles
    bus.out_ready = 1'b0;
    send(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h20, 8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h30, 8'h03, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("full_head", {55'd0, bus.out_valid, bus.diff}, {55'd0, 1'b1, bp_exp[0]});
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_head", {55'd0, bus.out_valid, bus.diff}, {55'd0, 1'b1, bp_exp[0]});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_order", {55'd0, bus.out_valid, bus.diff}, {55'd0, 1'b1, bp_exp[k]});
    end
    idle(4);

    // Width/split sweep: first 512 beats cover every 4-bit a, b, bin combination
    for (int k = 0; k < 10000; k++) begin
      sw_a = $urandom;
      sw_b = $urandom;
      sw_bin = 1'($urandom);
      if (k < 512) begin
        sw_a[3:0] = 4'(k);
        sw_b[3:0] = 4'(k >> 4);
        sw_bin = 1'(k >> 8);
      end
      sw_valid = 1'b1;
      @(negedge clk);
      check("sw_in_ready", {61'd0, bus4.in_ready, bus16.in_ready, bus32.in_ready}, 64'd7);
      s.a = sw_a;
      s.b = sw_b;
      s.bin = sw_bin;
      s.acc = cyc + 1;
      sq.push_back(s);
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;

    t = 0;
    while ((q.size() > 0 || sq.size() > 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (q.size() > 0 || sq.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: actual %0d/%0d beats outstanding required 0", q.size(), sq.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
